led_scale_pipe: RTL



---
 rtl/led_scale_pkg.sv | 13 +
 rtl/led_scale_lane.sv | 49 ++++
 rtl/led_scale_pipe.sv | 109 ++++++++++
 3 files changed

// File: rtl/led_scale_pkg.sv
// Shared constants and helpers for the LED brightness scaler.
package led_scale_pkg;

    localparam int PCT_W      = 7;
    localparam int PCT_MAX    = 100;
    localparam int ROUND_BIAS = 50;

    // Percent requests above full brightness are treated as full brightness.
    function automatic logic [PCT_W-1:0] clamp_pct(input logic [PCT_W-1:0] pct);
        return (pct > PCT_W'(PCT_MAX)) ? PCT_W'(PCT_MAX) : pct;
    endfunction

endpackage

// File: rtl/led_scale_lane.sv
// One colour channel of the scaler: stage 1 multiplies by the percent,
// stage 2 divides by 100 with optional round-half-up.
module led_scale_lane
    import led_scale_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load1,
    input  logic              load2,
    input  logic [DATA_W-1:0] pix,
    input  logic [PCT_W-1:0]  pct,
    input  logic              round_en,
    output logic [DATA_W-1:0] result
);

    localparam int PROD_W = DATA_W + PCT_W;

    logic [PROD_W-1:0] prod_q;
    logic              round_q;
    logic [PROD_W-1:0] biased;

    // Stage 1: capture the raw product and rounding mode of the accepted beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_q  <= '0;
            round_q <= 1'b0;
        end else if (load1) begin
            prod_q  <= PROD_W'(pix) * PROD_W'(pct);
            round_q <= round_en;
        end
    end

    // The bias cannot overflow: (2^DATA_W - 1) * 100 + 50 < 2^(DATA_W + 7).
    always_comb begin
        biased = prod_q + (round_q ? PROD_W'(ROUND_BIAS) : '0);
    end

    // Stage 2: exact constant divide; the quotient never exceeds the input pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= '0;
        end else if (load2) begin
            result <= DATA_W'(biased / PROD_W'(PCT_MAX));
        end
    end

endmodule

// File: rtl/led_scale_pipe.sv
// Streaming multi-channel brightness scaler with a per-frame percent ramp.
// Two-stage valid/ready pipeline; each beat is scaled by the percent in
// effect on the cycle it is accepted.
module led_scale_pipe
    import led_scale_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CHANNELS  = 3,
    parameter int RAMP_STEP = 4,
    parameter int RESET_PCT = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_start,
    input  logic [PCT_W-1:0]           target_pct,
    input  logic                       ramp_en,
    input  logic                       round_en,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [CHANNELS*DATA_W-1:0] s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [CHANNELS*DATA_W-1:0] m_data,
    output logic [PCT_W-1:0]           cur_pct,
    output logic                       ramp_busy
);

    logic             v1;
    logic             ready1;
    logic             ready2;
    logic             load1;
    logic             load2;
    logic [PCT_W-1:0] tgt;
    logic [PCT_W-1:0] step;
    logic [PCT_W-1:0] next_pct;

    assign ready2  = !m_valid || m_ready;
    assign ready1  = !v1 || ready2;
    assign s_ready = ready1;
    assign load1   = s_valid && ready1;
    assign load2   = v1 && ready2;

    // Stage valids advance whenever the stage ahead can take a beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            if (ready1) begin
                v1 <= s_valid;
            end
            if (ready2) begin
                m_valid <= v1;
            end
        end
    end

    genvar ch;
    generate
        for (ch = 0; ch < CHANNELS; ch++) begin : g_lane
            led_scale_lane #(
                .DATA_W (DATA_W)
            ) u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .load1    (load1),
                .load2    (load2),
                .pix      (s_data[ch*DATA_W +: DATA_W]),
                .pct      (cur_pct),
                .round_en (round_en),
                .result   (m_data[ch*DATA_W +: DATA_W])
            );
        end
    endgenerate

    assign tgt       = clamp_pct(target_pct);
    assign step      = PCT_W'(RAMP_STEP);
    assign ramp_busy = (cur_pct != tgt);

    // Next ramp value: snap when within one step, otherwise move one step without overshoot.
    always_comb begin
        next_pct = cur_pct;
        if (!ramp_en) begin
            next_pct = tgt;
        end else if (tgt > cur_pct) begin
            if ((tgt - cur_pct) <= step) begin
                next_pct = tgt;
            end else begin
                next_pct = cur_pct + step;
            end
        end else if (tgt < cur_pct) begin
            if ((cur_pct - tgt) <= step) begin
                next_pct = tgt;
            end else begin
                next_pct = cur_pct - step;
            end
        end
    end

    // Percent register updates only on frame boundaries so fades are frame-paced.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_pct <= PCT_W'(RESET_PCT);
        end else if (frame_start) begin
            cur_pct <= next_pct;
        end
    end

endmodule
